// File: rtl/rec_sequencer_if.sv
`timescale 1ns/1ps
// Channel bus between the sequencer and the three recorders (bit0=A, bit1=B, bit2=CENTER).
interface rec_sequencer_if;
  logic [2:0] rec_full;
  logic [2:0] send_busy;
  logic [2:0] recording;
  logic [2:0] sending;
  logic [1:0] txd_sel;

  modport master (
    input  rec_full,
    input  send_busy,
    output recording,
    output sending,
    output txd_sel
  );

  modport slave (
    output rec_full,
    output send_busy,
    input  recording,
    input  sending,
    input  txd_sel
  );
endinterface

// File: rtl/rec_sequencer.sv
`timescale 1ns/1ps
// Record/send session sequencer: records all three channels until full, then ships
// them one at a time over a shared TXD line with a fixed idle gap between transfers.
module rec_sequencer #(
  parameter int GAP_CYCLES  = 50000,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic             CLK50MHZ,
  input  logic             RST,
  input  logic             start,
  rec_sequencer_if.master  bus,
  output logic [7:0]       led,
  output logic [2:0]       dbg_state
);

  localparam int MAX_CNT = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REC, S_SEND, S_WAIT_HI, S_WAIT_LO, S_GAP, S_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ch_q, ch_d;
  logic [2:0]       full_q, full_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] sync_q;
  logic [1:0] vld_q;
  logic       prev_q;
  logic       start_edge;
  logic [2:0] ch_oh;
  logic       busy_ch;
  logic       active;
  logic [2:0] rec_v;

  // prev_q is held at 1 until the synchronizer has filled, so a button held
  // through reset must be released and pressed again to count as an edge.
  always_ff @(posedge CLK50MHZ or posedge RST) begin
    if (RST) begin
      sync_q <= 2'b00;
      vld_q  <= 2'b00;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], start};
      vld_q  <= {vld_q[0], 1'b1};
      prev_q <= vld_q[1] ? sync_q[1] : 1'b1;
    end
  end

  assign start_edge = vld_q[1] & sync_q[1] & ~prev_q;

  always_ff @(posedge CLK50MHZ or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      ch_q    <= 2'd0;
      full_q  <= 3'b000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      full_q  <= full_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake: sending[ch] is a one-cycle request; the recorder acknowledges by
  // raising send_busy[ch] for the whole transfer and dropping it when finished.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    full_d  = full_q;
    cnt_d   = cnt_q;
    ch_oh   = 3'b000;
    case (ch_q)
      2'd0:    ch_oh = 3'b001;
      2'd1:    ch_oh = 3'b010;
      2'd2:    ch_oh = 3'b100;
      default: ch_oh = 3'b000;
    endcase
    busy_ch = |(bus.send_busy & ch_oh);

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_edge) begin
          state_d = S_REC;
          ch_d    = 2'd0;
          full_d  = 3'b000;
          cnt_d   = '0;
        end
      end
      S_REC: begin
        full_d = full_q | bus.rec_full;
        if (&full_q) state_d = S_SEND;
      end
      S_SEND: begin
        state_d = S_WAIT_HI;
        cnt_d   = '0;
      end
      S_WAIT_HI: begin
        if (busy_ch)                state_d = S_WAIT_LO;
        else if (cnt_q == ACK_LAST) state_d = S_ERR;
        else                        cnt_d   = cnt_q + CNT_ONE;
      end
      S_WAIT_LO: begin
        if (!busy_ch) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (ch_q == 2'd2) begin
            state_d = S_DONE;
          end else begin
            ch_d    = ch_q + 2'd1;
            state_d = S_SEND;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    active = (state_q == S_SEND) || (state_q == S_WAIT_HI) ||
             (state_q == S_WAIT_LO) || (state_q == S_GAP);
    rec_v  = (state_q == S_REC) ? ~full_q : 3'b000;
  end

  assign bus.recording = rec_v;
  assign bus.sending   = (state_q == S_SEND) ? ch_oh : 3'b000;
  assign bus.txd_sel   = active ? ch_q : 2'd3;
  assign led           = {state_q == S_ERR, state_q == S_DONE,
                          active ? ch_oh : 3'b000, rec_v};
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_rec_sequencer.sv
`timescale 1ns/1ps
// Bench for rec_sequencer: a cycle-by-cycle vector table plus hand-written
// sessions using a behavioural recorder that holds send_busy for 20 cycles.
module tb_rec_sequencer;

  localparam int GAP = 10;
  localparam int ACK = 8;
  localparam int BUSY_LEN = 20;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_REC = 3'd1, ST_SEND = 3'd2,
                         ST_WHI = 3'd3, ST_WLO = 3'd4, ST_GAP = 3'd5,
                         ST_DONE = 3'd6, ST_ERR = 3'd7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] led;
  logic [2:0] dbg_state;

  rec_sequencer_if bus ();

  rec_sequencer #(.GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)) dut (
    .CLK50MHZ (clk),
    .RST      (rst),
    .start    (start),
    .bus      (bus),
    .led      (led),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    int         n;
    logic       st;
    logic [2:0] full;
    logic [2:0] busy;
    logic [2:0] e_state;
    logic [2:0] e_rec;
    logic [2:0] e_send;
    logic [1:0] e_txd;
    logic [7:0] e_led;
  } vec_t;

  vec_t tbl[$];

  // recorder model state
  logic [2:0] pend = 3'b000;
  int         bcnt = 0;

  function automatic vec_t mk(int n, logic st, logic [2:0] full, logic [2:0] busy,
                              logic [2:0] es, logic [2:0] er, logic [2:0] esd,
                              logic [1:0] et, logic [7:0] el);
    vec_t v;
    v.n = n; v.st = st; v.full = full; v.busy = busy;
    v.e_state = es; v.e_rec = er; v.e_send = esd; v.e_txd = et; v.e_led = el;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_update();
    if (pend != 3'b000) begin
      bus.send_busy = pend;
      bcnt = BUSY_LEN;
      pend = 3'b000;
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) bus.send_busy = 3'b000;
    end
  endtask

  task automatic begin_session();
    rst = 1'b1; start = 1'b0; bus.rec_full = 3'b000; bus.send_busy = 3'b000;
    pend = 3'b000; bcnt = 0;
    step(); step();
    rst = 1'b0;
    repeat (3) step();
    start = 1'b1; step();
    start = 1'b0; step(); step();
    bus.rec_full = 3'b111; step();
    bus.rec_full = 3'b000;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " state"},     32'(dbg_state),     32'(ST_IDLE));
    check({tag, " recording"}, 32'(bus.recording), 32'h0);
    check({tag, " sending"},   32'(bus.sending),   32'h0);
    check({tag, " txd_sel"},   32'(bus.txd_sel),   32'h3);
    check({tag, " led"},       32'(led),           32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p_t[3];
    int np;
    int viol;
    bit found;
    vec_t v;

    bus.rec_full  = 3'b000;
    bus.send_busy = 3'b000;

    // reset state
    step(); step();
    @(negedge clk);
    check_reset_outputs("reset");
    step();
    rst = 1'b0;
    repeat (3) step();

    //          n  st full  busy  state    rec   send  txd  led
    tbl.push_back(mk(2, 1, 3'b000, 3'b000, ST_IDLE, 3'b000, 3'b000, 2'd3, 8'h00));
    tbl.push_back(mk(1, 1, 3'b000, 3'b000, ST_IDLE, 3'b000, 3'b000, 2'd3, 8'h00));
    tbl.push_back(mk(1, 0, 3'b111, 3'b000, ST_REC,  3'b111, 3'b000, 2'd3, 8'h07));
    tbl.push_back(mk(1, 0, 3'b000, 3'b000, ST_REC,  3'b000, 3'b000, 2'd3, 8'h00));
    tbl.push_back(mk(1, 0, 3'b000, 3'b000, ST_SEND, 3'b000, 3'b001, 2'd0, 8'h08));
    tbl.push_back(mk(2, 0, 3'b000, 3'b110, ST_WHI,  3'b000, 3'b000, 2'd0, 8'h08));
    tbl.push_back(mk(1, 0, 3'b000, 3'b001, ST_WHI,  3'b000, 3'b000, 2'd0, 8'h08));
    tbl.push_back(mk(3, 0, 3'b000, 3'b001, ST_WLO,  3'b000, 3'b000, 2'd0, 8'h08));
    tbl.push_back(mk(1, 0, 3'b000, 3'b000, ST_WLO,  3'b000, 3'b000, 2'd0, 8'h08));
    tbl.push_back(mk(GAP, 0, 3'b000, 3'b000, ST_GAP, 3'b000, 3'b000, 2'd0, 8'h08));
    tbl.push_back(mk(1, 0, 3'b000, 3'b000, ST_SEND, 3'b000, 3'b010, 2'd1, 8'h10));
    tbl.push_back(mk(ACK, 0, 3'b000, 3'b000, ST_WHI, 3'b000, 3'b000, 2'd1, 8'h10));
    tbl.push_back(mk(3, 0, 3'b000, 3'b000, ST_ERR,  3'b000, 3'b000, 2'd3, 8'h80));
    tbl.push_back(mk(2, 1, 3'b000, 3'b000, ST_ERR,  3'b000, 3'b000, 2'd3, 8'h80));
    tbl.push_back(mk(1, 1, 3'b000, 3'b000, ST_ERR,  3'b000, 3'b000, 2'd3, 8'h80));
    tbl.push_back(mk(1, 0, 3'b000, 3'b000, ST_REC,  3'b111, 3'b000, 2'd3, 8'h07));
    tbl.push_back(mk(1, 0, 3'b010, 3'b000, ST_REC,  3'b111, 3'b000, 2'd3, 8'h07));
    tbl.push_back(mk(1, 0, 3'b000, 3'b000, ST_REC,  3'b101, 3'b000, 2'd3, 8'h05));
    tbl.push_back(mk(4, 1, 3'b000, 3'b000, ST_REC,  3'b101, 3'b000, 2'd3, 8'h05));
    tbl.push_back(mk(1, 0, 3'b101, 3'b000, ST_REC,  3'b101, 3'b000, 2'd3, 8'h05));
    tbl.push_back(mk(1, 0, 3'b000, 3'b000, ST_REC,  3'b000, 3'b000, 2'd3, 8'h00));
    tbl.push_back(mk(1, 0, 3'b000, 3'b000, ST_SEND, 3'b000, 3'b001, 2'd0, 8'h08));
    tbl.push_back(mk(1, 0, 3'b000, 3'b110, ST_WHI,  3'b000, 3'b000, 2'd0, 8'h08));

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      for (int k = 0; k < v.n; k++) begin
        start = v.st; bus.rec_full = v.full; bus.send_busy = v.busy;
        @(negedge clk);
        check($sformatf("v%0d.%0d state", i, k),     32'(dbg_state),     32'(v.e_state));
        check($sformatf("v%0d.%0d recording", i, k), 32'(bus.recording), 32'(v.e_rec));
        check($sformatf("v%0d.%0d sending", i, k),   32'(bus.sending),   32'(v.e_send));
        check($sformatf("v%0d.%0d txd_sel", i, k),   32'(bus.txd_sel),   32'(v.e_txd));
        check($sformatf("v%0d.%0d led", i, k),       32'(led),           32'(v.e_led));
        step();
      end
    end

    // start held high through reset: no session until released and pressed again
    rst = 1'b1; start = 1'b1; bus.send_busy = 3'b000; bus.rec_full = 3'b000;
    repeat (3) step();
    rst = 1'b0;
    repeat (6) step();
    @(negedge clk);
    check("held start no edge", 32'(dbg_state), 32'(ST_IDLE));
    step();
    start = 1'b0; repeat (3) step();
    start = 1'b1; repeat (4) step();
    @(negedge clk);
    check("re-press starts rec", 32'(dbg_state), 32'(ST_REC));
    step();
    start = 1'b0;

    // full session, extra start edge during the first gap
    begin_session();
    exp_q = '{2'd0, 2'd1, 2'd2};
    np = 0; viol = 0;
    for (int i = 0; i < 120; i++) begin
      model_update();
      start = (i == 25);
      @(negedge clk);
      if (|bus.sending) begin
        if (np < 3) p_t[np] = i;
        np++;
        pend = bus.sending;
        if (exp_q.size() > 0) begin
          logic [1:0] e;
          e = exp_q.pop_front();
          check($sformatf("pulse%0d txd_sel", np), 32'(bus.txd_sel), 32'(e));
          check($sformatf("pulse%0d sending", np), 32'(bus.sending), 32'(3'b001 << e));
        end else begin
          check("unexpected pulse", 32'(bus.sending), 32'h0);
        end
      end
      if ($countones(bus.sending) > 1 || (|bus.recording && |bus.sending)) viol++;
      step();
    end
    check("session pulse count", 32'(np), 32'd3);
    if (np >= 3) begin
      check("spacing 0->1", 32'(p_t[1] - p_t[0]), 32'(BUSY_LEN + GAP + 2));
      check("spacing 1->2", 32'(p_t[2] - p_t[1]), 32'(BUSY_LEN + GAP + 2));
    end
    @(negedge clk);
    check("done state",   32'(dbg_state),   32'(ST_DONE));
    check("done led",     32'(led),         32'h40);
    check("done txd_sel", 32'(bus.txd_sel), 32'h3);
    check("output invariants", 32'(viol),   32'd0);
    step();

    // asynchronous reset during WAIT_LO of channel B
    begin_session();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      model_update();
      @(negedge clk);
      if (|bus.sending) pend = bus.sending;
      if (dbg_state == ST_WLO && bus.txd_sel == 2'd1) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("reached wait_lo ch1", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async reset");
    step(); step();
    rst = 1'b0; bus.send_busy = 3'b000; pend = 3'b000; bcnt = 0;
    np = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (|bus.sending) np++;
      step();
    end
    check("pulses after reset", 32'(np), 32'd0);
    @(negedge clk);
    check("idle after reset", 32'(dbg_state), 32'(ST_IDLE));
    check("txd after reset",  32'(bus.txd_sel), 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
